// File: rtl/pipe_reg_pkg.sv
// pipe_reg_pkg: shared definitions for the elastic register pipeline.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default stage width and stage count
//   clog2()                       : constant width helper for the occupancy count
package pipe_reg_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Smallest w with 2**w >= n; used to size a counter that must hold 0..DEPTH.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/pipe_reg_if.sv
// pipe_reg_if: producer-side and consumer-side valid/ready handshake of pipe_reg.
//   in_valid/in_data/in_ready    : producer -> pipe
//   out_valid/out_data/out_ready : pipe -> consumer
// Modports:
//   slave  : the pipe itself (takes in_*, drives out_* and in_ready)
//   master : the environment around the pipe (producer and consumer)
interface pipe_reg_if import pipe_reg_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/pipe_stage.sv
// pipe_stage: one WIDTH-bit register slice with its own valid bit.
//   clk    : rising-edge clock
//   r      : synchronous active-low reset (clears valid and data)
//   i_clr  : synchronous clear of the valid bit (flush)
//   i_load : load i_d and mark the slice valid
//   i_hold : current contents cannot leave this cycle, keep the valid bit
//   i_d    : data to load
//   o_v    : slice holds valid data
//   o_d    : slice data
module pipe_stage import pipe_reg_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             r,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_hold,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_v,
  output logic [WIDTH-1:0] o_d
);

  logic             r_v;
  logic [WIDTH-1:0] r_d;

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // its neighbour's pre-edge value; blocking here would shift data through
  // several stages in one edge depending on evaluation order.
  always_ff @(posedge clk) begin
    if (!r) begin
      r_v <= 1'b0;
      // NOTE: data registers are reset as well so out_data reads 0 after reset,
      // not just the valid bits.
      r_d <= '0;
    end else begin
      if (i_clr) r_v <= 1'b0;
      else       r_v <= i_load | (r_v & i_hold);
      // Data only moves on a load; otherwise it holds, even when the slice empties.
      if (i_load) r_d <= i_d;
    end
  end

  assign o_v = r_v;
  assign o_d = r_d;

endmodule

// File: rtl/pipe_reg.sv
// pipe_reg: elastic register pipeline of DEPTH stages, WIDTH bits each, with
// valid/ready handshake, bubble collapsing and synchronous flush.
//   clk   : rising-edge clock, sole clock
//   r     : synchronous active-low reset, overrides flush and handshake
//   flush : clears every stage valid bit at the next edge; in_ready is 0 meanwhile
//   bus   : pipe_reg_if slave (in_valid/in_data/in_ready, out_valid/out_data/out_ready)
//   count : registered occupancy 0..DEPTH, present only when PIPE_REG_COUNT_EN is defined
// Optional feature macro: PIPE_REG_COUNT_EN
module pipe_reg import pipe_reg_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                          clk,
  input  logic                          r,
  input  logic                          flush,
  pipe_reg_if.slave                     bus
`ifdef PIPE_REG_COUNT_EN
  ,
  output logic [clog2(DEPTH+1)-1:0]     count
`endif
);

  logic [DEPTH-1:0] w_v;         // stage valid bits
  logic [DEPTH-1:0] w_free;      // stage i can accept new data this cycle
  logic [DEPTH-1:0] w_free_nxt;  // successor of stage i can accept (out_ready for the last)
  logic [DEPTH-1:0] w_load;      // stage i loads this edge
  logic [WIDTH-1:0] w_d   [DEPTH];
  logic [WIDTH-1:0] w_din [DEPTH];
  logic             w_accept;

  // Free chain, walked from the output back to the input. A stage is free when
  // it is empty or its own contents can move on. This gives an intentional
  // combinational path out_ready -> in_ready; in_valid never reaches in_ready.
  // NOTE: every output of this block is given a default before the loop, so no
  // bit can keep an old value and no latch is inferred.
  always_comb begin : free_chain
    logic f;
    w_free     = '0;
    w_free_nxt = '0;
    f          = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_free_nxt[i] = f;
      f             = !w_v[i] || f;
      w_free[i]     = f;
    end
  end

  assign bus.in_ready  = w_free[0] && !flush;
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign bus.out_valid = w_v[DEPTH-1];
  assign bus.out_data  = w_d[DEPTH-1];

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign w_load[g] = w_accept;
      assign w_din[g]  = bus.in_data;
    end else begin : g_body
      // Predecessor advances into this stage; suppressed during flush so the
      // data registers stay put while everything is being discarded.
      assign w_load[g] = w_v[g-1] && w_free[g] && !flush;
      assign w_din[g]  = w_d[g-1];
    end

    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk    (clk),
      .r      (r),
      .i_clr  (flush),
      .i_load (w_load[g]),
      .i_hold (!w_free_nxt[g]),
      .i_d    (w_din[g]),
      .o_v    (w_v[g]),
      .o_d    (w_d[g])
    );
  end

`ifdef PIPE_REG_COUNT_EN
  localparam int CW = clog2(DEPTH + 1);

  logic          w_emit;
  logic [CW-1:0] r_count;

  assign w_emit = bus.out_valid && bus.out_ready;

  // Accept and emit in the same cycle leave the occupancy unchanged.
  always_ff @(posedge clk) begin
    if (!r)                       r_count <= '0;
    else if (flush)               r_count <= '0;
    else if (w_accept && !w_emit) r_count <= r_count + CW'(1);
    else if (!w_accept && w_emit) r_count <= r_count - CW'(1);
  end

  assign count = r_count;

  a_count_bound : assert property (@(posedge clk) disable iff (!r) r_count <= CW'(DEPTH));
`endif

endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg: scoreboard bench for pipe_reg, one DEPTH=4/WIDTH=8 instance and
// one DEPTH=1/WIDTH=1 instance. Inputs change 1 time unit after the rising
// edge; outputs are sampled on the falling edge or 1 unit after the rising edge.
module tb_pipe_reg;

  logic clk;
  logic r;
  logic flush4;
  logic flush1;

  pipe_reg_if #(.WIDTH(8)) b4 ();
  pipe_reg_if #(.WIDTH(1)) b1 ();

`ifdef PIPE_REG_COUNT_EN
  logic [2:0] cnt4;
  logic [0:0] cnt1;
`endif

  pipe_reg #(.WIDTH(8), .DEPTH(4)) u_dut4 (
    .clk   (clk),
    .r     (r),
    .flush (flush4),
    .bus   (b4)
`ifdef PIPE_REG_COUNT_EN
    ,
    .count (cnt4)
`endif
  );

  pipe_reg #(.WIDTH(1), .DEPTH(1)) u_dut1 (
    .clk   (clk),
    .r     (r),
    .flush (flush1),
    .bus   (b1)
`ifdef PIPE_REG_COUNT_EN
    ,
    .count (cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: expected words pushed on accept, popped on emit.
  logic [7:0] q4 [$];
  logic [0:0] q1 [$];
  logic [7:0] exp4;
  logic [0:0] exp1;

  always @(negedge clk) begin
    if (!r) begin
      q4.delete();
    end else begin
      if (b4.out_valid && b4.out_ready) begin
        if (q4.size() == 0) check("d4_unexpected_emit", 32'(b4.out_valid), 32'd0);
        else begin
          exp4 = q4.pop_front();
          check("d4_out_data", 32'(b4.out_data), 32'(exp4));
        end
      end
      if (b4.in_valid && b4.in_ready) q4.push_back(b4.in_data);
      if (flush4) q4.delete();
    end
  end

  always @(negedge clk) begin
    if (!r) begin
      q1.delete();
    end else begin
      if (b1.out_valid && b1.out_ready) begin
        if (q1.size() == 0) check("d1_unexpected_emit", 32'(b1.out_valid), 32'd0);
        else begin
          exp1 = q1.pop_front();
          check("d1_out_data", 32'(b1.out_data), 32'(exp1));
        end
      end
      if (b1.in_valid && b1.in_ready) q1.push_back(b1.in_data);
      if (flush1) q1.delete();
    end
  end

  initial begin
    // Reset held two edges with a word presented.
    r            = 1'b0;
    flush4       = 1'b0;
    flush1       = 1'b0;
    b4.in_valid  = 1'b1;
    b4.in_data   = 8'hAA;
    b4.out_ready = 1'b0;
    b1.in_valid  = 1'b1;
    b1.in_data   = 1'b1;
    b1.out_ready = 1'b0;
    step();
    step();
    check("rst_out_valid4", 32'(b4.out_valid), 32'd0);
    check("rst_out_data4",  32'(b4.out_data),  32'd0);
    check("rst_out_valid1", 32'(b1.out_valid), 32'd0);
`ifdef PIPE_REG_COUNT_EN
    check("rst_count4", 32'(cnt4), 32'd0);
    check("rst_count1", 32'(cnt1), 32'd0);
`endif
    r           = 1'b1;
    b4.in_valid = 1'b0;
    b1.in_valid = 1'b0;
    #1;
    check("rst_in_ready4", 32'(b4.in_ready), 32'd1);
    check("rst_in_ready1", 32'(b1.in_ready), 32'd1);
    step();

    // Streaming: first word visible 3 edges after its accepting edge, no gaps.
    for (int i = 0; i < 12; i++) begin
      b4.in_valid  = 1'b1;
      b4.in_data   = 8'(i + 1);
      b4.out_ready = 1'b1;
      @(negedge clk);
      check("stream_out_valid", 32'(b4.out_valid), (i >= 4) ? 32'd1 : 32'd0);
      step();
    end
    b4.in_valid = 1'b0;
    repeat (6) step();

    // Backpressure: five words offered, four fit.
    b4.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      b4.in_valid = 1'b1;
      b4.in_data  = 8'(8'h41 + k);
      @(negedge clk);
      check("bp_in_ready", 32'(b4.in_ready), (k < 4) ? 32'd1 : 32'd0);
      step();
    end
    @(negedge clk);
    check("bp_full_in_ready", 32'(b4.in_ready),  32'd0);
    check("bp_out_valid",     32'(b4.out_valid), 32'd1);
    check("bp_out_data",      32'(b4.out_data),  32'h41);
`ifdef PIPE_REG_COUNT_EN
    check("bp_count", 32'(cnt4), 32'd4);
`endif
    step();
    b4.out_ready = 1'b1;
    @(negedge clk);
    check("bp_full_pass_in_ready", 32'(b4.in_ready), 32'd1);
    step();
    b4.in_valid = 1'b0;
    repeat (8) step();

    // Bubble collapse: 7, gap of two cycles, 9, with the consumer stalled.
    b4.out_ready = 1'b0;
    b4.in_valid  = 1'b1;
    b4.in_data   = 8'd7;
    step();
    b4.in_valid = 1'b0;
    step();
    step();
    b4.in_valid = 1'b1;
    b4.in_data  = 8'd9;
    step();
    b4.in_valid = 1'b0;
    repeat (4) step();
    @(negedge clk);
    check("bubble_head", 32'(b4.out_data), 32'd7);
`ifdef PIPE_REG_COUNT_EN
    check("bubble_count", 32'(cnt4), 32'd2);
`endif
    step();
    b4.out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("bubble_b2b", 32'(b4.out_valid), (j < 2) ? 32'd1 : 32'd0);
      step();
    end

    // Flush of a full pipe; the head word still transfers since out_ready=1.
    b4.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b4.in_valid = 1'b1;
      b4.in_data  = 8'(8'h51 + k);
      step();
    end
    flush4       = 1'b1;
    b4.in_valid  = 1'b1;
    b4.in_data   = 8'hEE;
    b4.out_ready = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 32'(b4.in_ready), 32'd0);
    step();
    flush4      = 1'b0;
    b4.in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 32'(b4.out_valid), 32'd0);
`ifdef PIPE_REG_COUNT_EN
    check("flush_count", 32'(cnt4), 32'd0);
`endif
    step();
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("flush_no_capture", 32'(b4.out_valid), 32'd0);
      step();
    end

    // Reset in the middle of traffic.
    b4.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      b4.in_valid = 1'b1;
      b4.in_data  = 8'(8'h61 + k);
      step();
    end
    b4.in_valid = 1'b0;
    r           = 1'b0;
    step();
    r = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 32'(b4.out_valid), 32'd0);
    check("midrst_in_ready",  32'(b4.in_ready),  32'd1);
`ifdef PIPE_REG_COUNT_EN
    check("midrst_count", 32'(cnt4), 32'd0);
`endif
    step();
    b4.out_ready = 1'b1;
    repeat (4) step();

    // DEPTH=1, WIDTH=1 with alternating consumer readiness.
    b1.in_valid = 1'b0;
    step();
    for (int k = 0; k < 20; k++) begin
      b1.in_valid  = 1'b1;
      b1.in_data   = 1'($urandom_range(0, 1));
      b1.out_ready = (k % 2 == 1);
      @(negedge clk);
      check("d1_in_ready",  32'(b1.in_ready),  ((k == 0) || (k % 2 == 1)) ? 32'd1 : 32'd0);
      check("d1_out_valid", 32'(b1.out_valid), (k >= 1) ? 32'd1 : 32'd0);
      step();
    end
    b1.in_valid  = 1'b0;
    b1.out_ready = 1'b1;
    repeat (3) step();

    @(negedge clk);
    check("d4_drained", 32'(q4.size()), 32'd0);
    check("d1_drained", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_reg.md
# pipe_reg

Parametrised elastic register pipeline: a chain of DEPTH register stages, each WIDTH bits wide with its own valid bit, moving data under a valid/ready handshake with bubble collapsing and synchronous flush. It generalises the single-bit resettable flip-flop into the standard delay and retiming element for the game datapath. It sits between producers and consumers such as input decode, game logic and VGA/display feeders, wherever a multi-cycle, back-pressurable delay is needed.

## Interface
- WIDTH, 8, data bits per stage (≥1)
- DEPTH, 4, number of register stages (≥1)
- CW, $clog2(DEPTH+1), occupancy count width (derived, not overridden)

- clk  in  1  rising-edge clock, sole clock
- r  in  1  reset, synchronous, active-low (r==0 resets on rising clk)
- flush  in  1  synchronous clear of all stage valid bits
- in_valid  in  1  producer has data
- in_data  in  WIDTH  producer data
- in_ready  out  1  pipe accepts in_data this cycle
- out_valid  out  1  last stage holds valid data
- out_data  out  WIDTH  last stage data
- out_ready  in  1  consumer takes out_data this cycle
- count  out  CW  valid stages held (present only with PIPE_REG_COUNT_EN)

## Operation
- Stage i holds v[i] and d[i]. Stage 0 is input-side; stage DEPTH-1 drives out_valid/out_data.
- Move rule: stage DEPTH-1 is free when !v[DEPTH-1] || out_ready. Stage i<DEPTH-1 is free when !v[i] || (stage i+1 free). in_ready = stage 0 free && !flush.
- On a clock edge, every valid stage whose successor is free advances one stage. An empty stage upstream of a held stage fills, so bubbles collapse.
- Accept when in_valid && in_ready: stage 0 loads in_data and sets v[0].
- Transfer out when out_valid && out_ready.
- flush=1: all v[] cleared next edge. in_ready is 0, so incoming data is discarded. Outputs presented this cycle still count as transferred if out_ready=1.
- Data registers load only on advance/accept. They hold their value otherwise.
- Order is strictly preserved. No duplication, no loss except on flush/reset.
- Reset (r==0) overrides flush and handshake: all v[]=0, all d[]=0, count=0.

## Timing
- Reset values: in_ready=1 combinationally once r==1 and flush==0. out_valid=0, out_data=0, count=0.
- Latency: a word accepted at edge E appears with out_valid=1 after edge E+(DEPTH-1). DEPTH=1 gives out_valid the cycle after acceptance.
- Throughput: one word per cycle when out_ready held 1. A full pipe with out_ready=1 accepts and emits in the same cycle.
- Full (all v[]=1) with out_ready=0: in_ready=0, outputs stable until taken.
- Combinational path out_ready → in_ready through the free chain is intentional and documented. No path from in_valid to in_ready.
- Reset asserted mid-stream: contents lost at the next edge, out_valid=0 the following cycle.
- Simultaneous accept+emit keeps count unchanged.

## Configuration
- PIPE_REG_COUNT_EN defined: count port exists. It is a registered occupancy counter: +1 on accept, −1 on emit, net 0 on both, 0 on flush/reset. The bound 0..DEPTH is asserted in simulation.
- Undefined: count port and counter logic absent. All other behaviour identical.

## Structure
- Package pipe_reg_pkg holds the count-width function clog2 for CW and a localparam for the default WIDTH/DEPTH.
- Sub-module pipe_stage: one WIDTH-bit register slice with valid bit, load enable, and synchronous active-low reset. It is instantiated DEPTH times via generate.
- Free-chain logic and the counter live in pipe_reg.

## Test plan
- Reset: r=0 two cycles with in_valid=1, in_data=8'hAA → out_valid=0, out_data=0, count=0. After r=1, in_ready=1.
- Streaming, DEPTH=4: in_data 1,2,3,… every cycle with out_ready=1 → out_data 1,2,3,… starting 3 edges after first accept, no gaps.
- Backpressure: out_ready=0 while feeding 5 words → 4 accepted, in_ready=0, count=4. Then out_ready=1 → words 1..4 then 5 in order.
- Bubble collapse: feed words 7 and 9 with a 2-cycle gap, out_ready=0 → both stack in the last two stages. On release they emit on back-to-back cycles.
- Flush: full pipe, flush=1 one cycle with in_valid=1 → next cycle out_valid=0, count=0, incoming word not captured.
- DEPTH=1, WIDTH=1: alternating out_ready → each 1-bit word emitted exactly once. Accept and emit coincide when full and out_ready=1.
